// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types for the FIFO read-side stream adapter
package fifo_pkg;

    typedef enum logic [1:0] {
        OCC_0,
        OCC_1,
        OCC_2
    } rd_occ_e;

    localparam int RD_SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus valid/ready output stream
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
) ();

    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] out_data;

    // master: the stream adapter; slave: the FIFO and the downstream consumer
    modport master (
        input  rdata,
        input  rempty,
        output rinc,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        output rdata,
        output rempty,
        input  rinc,
        input  out_valid,
        output out_ready,
        input  out_data
    );

endinterface

// File: rtl/fifo_rd_stats.sv
// rtl/fifo_rd_stats.sv - saturating delivered-word counter
module fifo_rd_stats #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNTW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - async FIFO read port to registered valid/ready stream, 2-entry skid
// Optional delivered-word counter enabled by FIFO_RD_STATS_EN.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              rflush,
    fifo_rd_stream_if.master  bus
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNTW-1:0]   rd_count
`endif
);

    if (CNTW < 1) begin : g_bad_cntw
        $error("fifo_rd_stream: CNTW must be at least 1");
    end

    rd_occ_e          occ_q, occ_d;
    logic [DSIZE-1:0] main_q, main_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic             pop;
    logic             push;

    assign bus.out_valid = (occ_q != OCC_0);
    assign bus.out_data  = main_q;
    assign bus.rinc      = push;

    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        pop    = bus.out_valid & bus.out_ready;
        // A full buffer may only take a word when the consumer frees a slot in the same cycle.
        push   = ~rrst & ~rflush & ~bus.rempty & ((occ_q != OCC_2) | bus.out_ready);

        case (occ_q)
            OCC_0:   occ_d = push ? OCC_1 : OCC_0;
            OCC_1: begin
                if (push && !pop)      occ_d = OCC_2;
                else if (!push && pop) occ_d = OCC_0;
                else                   occ_d = OCC_1;
            end
            OCC_2:   occ_d = (pop && !push) ? OCC_1 : OCC_2;
            default: occ_d = OCC_0;
        endcase

        if (pop && (occ_q == OCC_2)) begin
            main_d = skid_q;
        end

        // Incoming word lands in slot (occ - pop): skid when it would sit behind a held word.
        if (push) begin
            if ((occ_q == OCC_2) || ((occ_q == OCC_1) && !pop)) begin
                skid_d = bus.rdata;
            end else begin
                main_d = bus.rdata;
            end
        end

        if (rflush) begin
            occ_d = OCC_0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ_q  <= OCC_0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

`ifdef FIFO_RD_STATS_EN
    fifo_rd_stats #(
        .CNTW (CNTW)
    ) u_stats (
        .clk   (rclk),
        .rst   (rrst),
        .inc   (pop),
        .count (rd_count)
    );
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed bench for fifo_rd_stream with a queue-based FIFO model
module tb_fifo_rd_stream;

    localparam int DSIZE = 8;
    localparam int CNTW  = 4;

    logic clk;
    logic rrst;
    logic rflush;
`ifdef FIFO_RD_STATS_EN
    logic [CNTW-1:0] rd_count;
`endif

    fifo_rd_stream_if #(.DSIZE(DSIZE)) bus ();

    fifo_rd_stream #(
        .DSIZE (DSIZE),
        .CNTW  (CNTW)
    ) dut (
        .rclk     (clk),
        .rrst     (rrst),
        .rflush   (rflush),
        .bus      (bus)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count (rd_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [DSIZE-1:0] fq[$];
    logic             force_empty;
    logic             obs_rinc;
    logic             obs_valid;
    logic [DSIZE-1:0] obs_data;

    task automatic present();
        bus.rempty = force_empty || (fq.size() == 0);
        bus.rdata  = (fq.size() > 0) ? fq[0] : '0;
    endtask

    // Observe the current cycle before its closing edge, then advance the FIFO model.
    task automatic cycle();
        logic             took;
        logic [DSIZE-1:0] dropped;
        @(negedge clk);
        obs_rinc  = bus.rinc;
        obs_valid = bus.out_valid;
        obs_data  = bus.out_data;
        took      = bus.rinc;
        @(posedge clk);
        #1;
        if (took && fq.size() > 0) dropped = fq.pop_front();
        present();
    endtask

    task automatic load(input int n, input logic [DSIZE-1:0] first);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(first + DSIZE'(i));
        present();
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        rflush = 1'b0;
        bus.out_ready = 1'b0;
        force_empty = 1'b0;
        load(3, 8'h77);
        cycle();
        for (int c = 0; c < 2; c++) begin
            cycle();
            vectors++;
            if (obs_rinc !== 1'b0) begin
                $display("FAIL reset_rinc[%0d]: got %b want 0", c, obs_rinc); miscompares++;
            end
            vectors++;
            if (obs_valid !== 1'b0) begin
                $display("FAIL reset_valid[%0d]: got %b want 0", c, obs_valid); miscompares++;
            end
            vectors++;
            if (obs_data !== 8'h00) begin
                $display("FAIL reset_data[%0d]: got %h want 00", c, obs_data); miscompares++;
            end
        end
`ifdef FIFO_RD_STATS_EN
        vectors++;
        if (rd_count !== 4'd0) begin
            $display("FAIL reset_count: got %0d want 0", rd_count); miscompares++;
        end
`endif
        load(0, 8'h00);
        rrst = 1'b0;
    endtask

    task automatic test_stream();
        load(8, 8'h01);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            vectors++;
            if (obs_rinc !== (k < 8)) begin
                $display("FAIL stream_rinc[%0d]: got %b want %b", k, obs_rinc, (k < 8)); miscompares++;
            end
            vectors++;
            if (obs_valid !== (k >= 1 && k <= 8)) begin
                $display("FAIL stream_valid[%0d]: got %b want %b", k, obs_valid, (k >= 1 && k <= 8));
                miscompares++;
            end
            if (k >= 1 && k <= 8) begin
                vectors++;
                if (obs_data !== DSIZE'(k)) begin
                    $display("FAIL stream_data[%0d]: got %h want %h", k, obs_data, DSIZE'(k)); miscompares++;
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int               pulses;
        logic [DSIZE-1:0] exp_data [4];
        logic             exp_rinc [5];
        exp_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        exp_rinc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        pulses = 0;
        load(4, 8'hA0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (obs_rinc) pulses++;
            if (k >= 1) begin
                vectors++;
                if (obs_valid !== 1'b1 || obs_data !== 8'hA0) begin
                    $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=a0", k, obs_valid, obs_data);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (pulses != 2) begin
            $display("FAIL bp_rinc_pulses: got %0d want 2", pulses); miscompares++;
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            vectors++;
            if (obs_rinc !== exp_rinc[k]) begin
                $display("FAIL bp_drain_rinc[%0d]: got %b want %b", k, obs_rinc, exp_rinc[k]); miscompares++;
            end
            if (k < 4) begin
                vectors++;
                if (obs_valid !== 1'b1 || obs_data !== exp_data[k]) begin
                    $display("FAIL bp_drain_data[%0d]: got v=%b d=%h want v=1 d=%h",
                             k, obs_valid, obs_data, exp_data[k]);
                    miscompares++;
                end
            end else begin
                vectors++;
                if (obs_valid !== 1'b0) begin
                    $display("FAIL bp_drain_end: got v=%b want 0", obs_valid); miscompares++;
                end
            end
        end
    endtask

    task automatic test_starve();
        bus.out_ready = 1'b0;
        load(1, 8'h55);
        cycle();
        force_empty = 1'b1;
        fq.push_back(8'h66);
        present();
        bus.out_ready = 1'b1;
        cycle();
        vectors++;
        if (obs_rinc !== 1'b0 || obs_valid !== 1'b1 || obs_data !== 8'h55) begin
            $display("FAIL starve_deliver: got r=%b v=%b d=%h want r=0 v=1 d=55", obs_rinc, obs_valid, obs_data);
            miscompares++;
        end
        cycle();
        vectors++;
        if (obs_rinc !== 1'b0 || obs_valid !== 1'b0) begin
            $display("FAIL starve_after: got r=%b v=%b want r=0 v=0", obs_rinc, obs_valid); miscompares++;
        end
        force_empty = 1'b0;
        load(0, 8'h00);
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        load(3, 8'h11);
        cycle();
        cycle();
        cycle();
        vectors++;
        if (obs_valid !== 1'b1 || obs_data !== 8'h11 || obs_rinc !== 1'b0) begin
            $display("FAIL flush_full: got r=%b v=%b d=%h want r=0 v=1 d=11", obs_rinc, obs_valid, obs_data);
            miscompares++;
        end
        rflush = 1'b1;
        cycle();
        vectors++;
        if (obs_rinc !== 1'b0) begin
            $display("FAIL flush_rinc: got %b want 0", obs_rinc); miscompares++;
        end
        rflush = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        vectors++;
        if (obs_valid !== 1'b0 || obs_rinc !== 1'b1) begin
            $display("FAIL flush_after: got r=%b v=%b want r=1 v=0", obs_rinc, obs_valid); miscompares++;
        end
        cycle();
        vectors++;
        if (obs_valid !== 1'b1 || obs_data !== 8'h13) begin
            $display("FAIL flush_next_word: got v=%b d=%h want v=1 d=13", obs_valid, obs_data); miscompares++;
        end
        cycle();
        vectors++;
        if (obs_valid !== 1'b0) begin
            $display("FAIL flush_drained: got v=%b want 0", obs_valid); miscompares++;
        end
    endtask

`ifdef FIFO_RD_STATS_EN
    task automatic test_stats();
        // 8 + 4 + 1 + 1 words delivered by the earlier scenarios
        vectors++;
        if (rd_count !== 4'd14) begin
            $display("FAIL stats_count14: got %0d want 14", rd_count); miscompares++;
        end
        bus.out_ready = 1'b1;
        load(6, 8'h30);
        for (int k = 0; k < 8; k++) cycle();
        vectors++;
        if (rd_count !== 4'd15) begin
            $display("FAIL stats_saturate: got %0d want 15", rd_count); miscompares++;
        end
        rflush = 1'b1;
        cycle();
        rflush = 1'b0;
        cycle();
        vectors++;
        if (rd_count !== 4'd15) begin
            $display("FAIL stats_flush_keep: got %0d want 15", rd_count); miscompares++;
        end
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        vectors++;
        if (rd_count !== 4'd0) begin
            $display("FAIL stats_reset: got %0d want 0", rd_count); miscompares++;
        end
    endtask
`endif

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rrst          = 1'b1;
        rflush        = 1'b0;
        force_empty   = 1'b0;
        bus.out_ready = 1'b0;
        bus.rempty    = 1'b1;
        bus.rdata     = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_starve();
        test_flush();
`ifdef FIFO_RD_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
